// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage register.
//   state_t        - stage occupancy state; the encoding equals the number of
//                    held entries, so it drives occupancy_o directly.
//   DEFAULT_DATA_W - default payload width (pc + instr).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 64;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears the count
//   inc_i  - increment request for this cycle
//   cnt_o  - current count, saturates at 2^W-1
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with a one-entry skid buffer,
// synchronous flush and optional performance counters.
//
// Optional feature macro: PIPE_STAGE_PERF_EN (adds stall/bubble counters).
//
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   flush_i         - synchronous flush, discards every held entry
//   in_valid_i/in_ready_o/in_data_i    - upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o - downstream handshake and payload
//   occupancy_o     - held entries (0..2), also the FSM state for debug
//   stall_cnt_o     - cycles with out_valid_o & !out_ready_i (PERF_EN only)
//   bubble_cnt_o    - cycles with !out_valid_o (PERF_EN only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and while out_valid_o is high with
// out_ready_i low, out_data_o stays stable. in_ready_o comes straight from a
// flop, so there is no path from out_ready_i to in_ready_o.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    state_t            state, state_n;
    logic [DATA_W-1:0] main_q, main_n;
    logic [DATA_W-1:0] skid_q, skid_n;
    logic              ready_q, valid_q;
    logic              in_fire, out_fire;

    assign in_fire  = in_valid_i & ready_q;
    assign out_fire = valid_q & out_ready_i;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush_i) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_n = ONE;
                        main_n  = in_data_i;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_n = in_data_i;
                    end else if (in_fire) begin
                        state_n = FULL;
                        skid_n  = in_data_i;
                    end else if (out_fire) begin
                        // Zeroing main keeps out_data_o at 0 while empty.
                        state_n = EMPTY;
                        main_n  = '0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_n = ONE;
                        main_n  = skid_q;
                        skid_n  = '0;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = '0;
                    skid_n  = '0;
                end
            endcase
        end
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
            ready_q <= (state_n != FULL);
            valid_q <= (state_n != EMPTY);
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;
    assign occupancy_o = state;

`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (valid_q & ~out_ready_i),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (~valid_q),
        .cnt_o  (bubble_cnt_o)
    );
`else
    // Counter width is meaningless without the counters.
    logic unused_cnt_w;
    assign unused_cnt_w = ^{1'b0, CNT_W[0]};
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized and directed bench for pipe_stage_skid.
// The reference is a bounded queue (capacity 2) of held payloads; outputs are
// derived from its size and head. Counter checks exist when
// PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
`ifdef PIPE_STAGE_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .bubble_cnt_o(bubble_cnt)
`endif
    );

    int total_checks = 0;
    int pass_checks  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end else begin
            pass_checks++;
        end
    endtask

    // ---------------- reference model + compare ----------------
    logic [DATA_W-1:0] exp_q[$];
    longint            m_stall = 0;
    longint            m_bubble = 0;
    longint            cnt_cap;
    initial cnt_cap = (longint'(1) << CNT_W) - 1;

    always @(posedge clk) begin
        bit acc, dlv;
        acc = in_valid && (exp_q.size() < 2);
        dlv = out_ready && (exp_q.size() > 0);
        if (!rst_n) begin
            exp_q.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (exp_q.size() == 0 && m_bubble < cnt_cap) m_bubble++;
            if (exp_q.size() > 0 && !out_ready && m_stall < cnt_cap) m_stall++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (dlv) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(in_data);
            end
        end
        #1;
        chk("model_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("model_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        chk("model_occupancy", 64'(occupancy), 64'(exp_q.size()));
        chk("model_out_data", 64'(out_data), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk("model_stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("model_bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
    end

    // ---------------- driver ----------------
    // Drive on the falling edge, then sample 2 time units after the next rise.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset then idle.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #2;
            chk("idle_out_valid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
            chk("idle_bubble_cnt", 64'(bubble_cnt), 64'(i));
`endif
        end

        // Streaming.
        step(1'b1, 64'h11, 1'b1, 1'b0);
        chk("stream_0x11", 64'(out_data), 64'h11);
        step(1'b1, 64'h22, 1'b1, 1'b0);
        chk("stream_0x22", 64'(out_data), 64'h22);
        step(1'b1, 64'h33, 1'b1, 1'b0);
        chk("stream_0x33", 64'(out_data), 64'h33);
        chk("stream_valid", 64'(out_valid), 64'd1);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Skid fill and drain.
        step(1'b1, 64'hA, 1'b0, 1'b0);
        chk("skid_occ1", 64'(occupancy), 64'd1);
        chk("skid_ready1", 64'(in_ready), 64'd1);
        step(1'b1, 64'hB, 1'b0, 1'b0);
        chk("skid_occ2", 64'(occupancy), 64'd2);
        chk("skid_ready0", 64'(in_ready), 64'd0);
        chk("skid_hold_a", 64'(out_data), 64'hA);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("skid_deliver_b", 64'(out_data), 64'hB);
        chk("skid_ready_back", 64'(in_ready), 64'd1);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("skid_empty", 64'(occupancy), 64'd0);

        // Flush while FULL with an incoming payload.
        step(1'b1, 64'h1, 1'b0, 1'b0);
        step(1'b1, 64'h2, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b0, 1'b1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_data), 64'd0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("flush_no_deliver", 64'(out_valid), 64'd0);

        // Flush in ONE drops a payload handshaken in the same cycle.
        step(1'b1, 64'h7, 1'b0, 1'b0);
        step(1'b1, 64'h8, 1'b1, 1'b1);
        chk("flush_one_occ", 64'(occupancy), 64'd0);

        // Long downstream stall.
        step(1'b1, 64'h5, 1'b0, 1'b0);
        repeat (20) step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("stall_data_stable", 64'(out_data), 64'h5);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_saturated", 64'(stall_cnt), 64'd15);
`endif
        step(1'b0, 64'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset mid-cycle while FULL.
        step(1'b1, 64'hE1, 1'b0, 1'b0);
        step(1'b1, 64'hE2, 1'b0, 1'b0);
        chk("pre_reset_full", 64'(occupancy), 64'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        chk("async_out_data", 64'(out_data), 64'd0);
        chk("async_occupancy", 64'(occupancy), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("async_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("post_reset_empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
